// File: rtl/hci_l2_bank_adapter.sv
// rtl/hci_l2_bank_adapter.sv - L2 interconnect bank port to single-port SRAM adapter with partial-write RMW
//
// Purpose:
//   Sits between one memory-side port of the L2 log interconnect and a
//   single-port SRAM macro with 1-cycle read latency. Reads and full-word
//   writes pass straight through. When the macro lacks byte enables
//   (BE_SUPPORT=0), partial writes become a read followed by a merged
//   full-word write in the next cycle. Responses (valid/id/data) appear one
//   cycle after grant.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i, add_i, wen_i,   interconnect request (wen_i=1 read, 0 write),
//   data_i, be_i, id_i     word address, write data, byte enables, ID
//   gnt_o                  grant (combinational, independent of req_i)
//   r_valid_o, r_data_o,   response, one cycle after grant
//   r_id_o
//   sram_req_o, sram_we_o, SRAM macro command (we=1 write)
//   sram_addr_o,
//   sram_wdata_o, sram_be_o
//   sram_rdata_i           SRAM read data, valid the cycle after a read
module hci_l2_bank_adapter #(
    parameter int unsigned AW         = 14,
    parameter int unsigned DW         = 32,
    parameter int unsigned BW         = 8,
    parameter int unsigned IW         = 20,
    parameter bit          BE_SUPPORT = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [AW-1:0]      add_i,
    input  logic               wen_i,
    input  logic [DW-1:0]      data_i,
    input  logic [DW/BW-1:0]   be_i,
    input  logic [IW-1:0]      id_i,
    output logic               gnt_o,
    output logic               r_valid_o,
    output logic [DW-1:0]      r_data_o,
    output logic [IW-1:0]      r_id_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [DW-1:0]      sram_wdata_o,
    output logic [DW/BW-1:0]   sram_be_o,
    input  logic [DW-1:0]      sram_rdata_i
);

    localparam int unsigned NB = DW / BW;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   rmw_addr_q;
    logic [DW-1:0]   rmw_data_q;
    logic [NB-1:0]   rmw_be_q;
    logic            r_valid_q;
    logic [IW-1:0]   r_id_q;
    logic            rd_flag_q;

    logic            accept;
    logic            be_full;
    logic            be_null;
    logic            is_partial;
    logic [DW-1:0]   merged_wdata;

    assign gnt_o      = ~rst_i & (state_q == ST_IDLE);
    assign accept     = req_i & gnt_o;
    assign be_full    = &be_i;
    assign be_null    = ~|be_i;
    assign is_partial = (BE_SUPPORT == 1'b0) & ~wen_i & ~be_full & ~be_null;

    // Old word comes back from the SRAM read issued in the accept cycle;
    // bytes selected by the latched enables are replaced with new data.
    always_comb begin
        merged_wdata = '0;
        for (int b = 0; b < NB; b++) begin
            merged_wdata[b*BW +: BW] = rmw_be_q[b] ? rmw_data_q[b*BW +: BW]
                                                   : sram_rdata_i[b*BW +: BW];
        end
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (!rst_i) begin
            if (state_q == ST_RMW_WR) begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = rmw_addr_q;
                sram_wdata_o = merged_wdata;
                sram_be_o    = '1;
            end else if (accept) begin
                if (wen_i || is_partial) begin
                    // Plain read, or the read half of a read-modify-write.
                    sram_req_o  = 1'b1;
                    sram_addr_o = add_i;
                    sram_be_o   = '1;
                end else if (!be_null) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = add_i;
                    sram_wdata_o = data_i;
                    sram_be_o    = be_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
            rmw_be_q   <= '0;
            r_valid_q  <= 1'b0;
            r_id_q     <= '0;
            rd_flag_q  <= 1'b0;
        end else begin
            r_valid_q <= accept;
            rd_flag_q <= accept & wen_i;
            if (accept) begin
                r_id_q <= id_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_partial) begin
                        state_q    <= ST_RMW_WR;
                        rmw_addr_q <= add_i;
                        rmw_data_q <= data_i;
                        rmw_be_q   <= be_i;
                    end
                end
                ST_RMW_WR: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    assign r_data_o  = rd_flag_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_hci_l2_bank_adapter.sv
// tb/tb_hci_l2_bank_adapter.sv - self-checking bench for hci_l2_bank_adapter
module tb_hci_l2_bank_adapter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int IW = 20;
    localparam int NB = DW / BW;

    logic            clk_i;
    logic            rst_i;
    logic            req_i;
    logic [AW-1:0]   add_i;
    logic            wen_i;
    logic [DW-1:0]   data_i;
    logic [NB-1:0]   be_i;
    logic [IW-1:0]   id_i;
    logic            gnt_o;
    logic            r_valid_o;
    logic [DW-1:0]   r_data_o;
    logic [IW-1:0]   r_id_o;
    logic            sram_req_o;
    logic            sram_we_o;
    logic [AW-1:0]   sram_addr_o;
    logic [DW-1:0]   sram_wdata_o;
    logic [NB-1:0]   sram_be_o;
    logic [DW-1:0]   sram_rdata_i;

    int n_cmp;
    int n_err;

    hci_l2_bank_adapter #(
        .AW(AW), .DW(DW), .BW(BW), .IW(IW), .BE_SUPPORT(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i),
        .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .r_id_o(r_id_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM macro model: 1-cycle read latency, byte-masked writes, preload port.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk_i) begin
        if (pl_en) sram_mem[pl_addr] <= pl_data;
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < NB; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o][b*BW +: BW] <= sram_wdata_o[b*BW +: BW];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    // Reference memory: updated in transaction order at accept time.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++)
            if (be[b]) r[b*BW +: BW] = new_w[b*BW +: BW];
        return r;
    endfunction

    task automatic drive(input logic rst, input logic req, input logic wen,
                         input logic [AW-1:0] add, input logic [DW-1:0] data,
                         input logic [NB-1:0] be, input logic [IW-1:0] id);
        @(negedge clk_i);
        rst_i  = rst;
        req_i  = req;
        wen_i  = wen;
        add_i  = add;
        data_i = data;
        be_i   = be;
        id_i   = id;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk_i);
        req_i   = 1'b0;
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk_i);
        pl_en   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 14'h5, 32'h1234_5678, 4'h3, 20'h1);
            n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b expected 0", gnt_o); end
            n_cmp++; if ({sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o} !== '0) begin
                n_err++; $display("FAIL reset_sram: got req=%b we=%b addr=%h wdata=%h be=%h expected all 0",
                                  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o); end
            n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b expected 0", r_valid_o); end
        end
        idle();
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL post_reset_gnt: got %b expected 1", gnt_o); end
        n_cmp++; if (r_id_o !== '0) begin n_err++; $display("FAIL post_reset_rid: got %h expected 0", r_id_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL post_reset_rvalid: got %b expected 0", r_valid_o); end
    endtask

    task automatic test_read();
        preload(14'h10, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 1'b1, 14'h10, 32'h0, 4'hF, 20'h00004);
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL read_gnt: got %b expected 1", gnt_o); end
        n_cmp++; if ({sram_req_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b0, 14'h10}) begin
            n_err++; $display("FAIL read_sram_cmd: got req=%b we=%b addr=%h expected 1 0 0010", sram_req_o, sram_we_o, sram_addr_o); end
        idle();
        n_cmp++; if (r_valid_o !== 1'b1) begin n_err++; $display("FAIL read_rvalid: got %b expected 1", r_valid_o); end
        n_cmp++; if (r_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_rdata: got %h expected deadbeef", r_data_o); end
        n_cmp++; if (r_id_o !== 20'h00004) begin n_err++; $display("FAIL read_rid: got %h expected 00004", r_id_o); end
    endtask

    task automatic test_partial_write();
        preload(14'h20, 32'h1122_3344);
        drive(1'b0, 1'b1, 1'b0, 14'h20, 32'hAABB_CCDD, 4'b0101, 20'h00007);
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL pw_gnt0: got %b expected 1", gnt_o); end
        n_cmp++; if ({sram_req_o, sram_we_o, sram_addr_o} !== {1'b1, 1'b0, 14'h20}) begin
            n_err++; $display("FAIL pw_sram_rd: got req=%b we=%b addr=%h expected 1 0 0020", sram_req_o, sram_we_o, sram_addr_o); end
        ref_mem[14'h20] = merge(ref_mem[14'h20], 32'hAABB_CCDD, 4'b0101);
        // Following read is presented during the merge cycle and must be held.
        drive(1'b0, 1'b1, 1'b1, 14'h20, 32'h0, 4'hF, 20'h00008);
        n_cmp++; if (gnt_o !== 1'b0) begin n_err++; $display("FAIL pw_gnt1: got %b expected 0", gnt_o); end
        n_cmp++; if ({sram_req_o, sram_we_o, sram_addr_o, sram_be_o} !== {1'b1, 1'b1, 14'h20, 4'hF}) begin
            n_err++; $display("FAIL pw_sram_wr: got req=%b we=%b addr=%h be=%h expected 1 1 0020 f", sram_req_o, sram_we_o, sram_addr_o, sram_be_o); end
        n_cmp++; if (sram_wdata_o !== 32'h11BB_33DD) begin n_err++; $display("FAIL pw_wdata: got %h expected 11bb33dd", sram_wdata_o); end
        n_cmp++; if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 20'h00007, 32'h0}) begin
            n_err++; $display("FAIL pw_resp: got valid=%b id=%h data=%h expected 1 00007 0", r_valid_o, r_id_o, r_data_o); end
        drive(1'b0, 1'b1, 1'b1, 14'h20, 32'h0, 4'hF, 20'h00008);
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL pw_gnt2: got %b expected 1", gnt_o); end
        n_cmp++; if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL pw_rvalid_gap: got %b expected 0", r_valid_o); end
        idle();
        n_cmp++; if ({r_valid_o, r_id_o} !== {1'b1, 20'h00008}) begin
            n_err++; $display("FAIL pw_readback_resp: got valid=%b id=%h expected 1 00008", r_valid_o, r_id_o); end
        n_cmp++; if (r_data_o !== 32'h11BB_33DD) begin n_err++; $display("FAIL pw_readback_data: got %h expected 11bb33dd", r_data_o); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [4];
        logic [DW-1:0] d [4];
        for (int i = 0; i < 4; i++) begin
            a[i] = AW'(32'h200 + i * 16 + $urandom_range(0, 15));
            d[i] = $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, (i >= 4), a[i % 4], d[i % 4], 4'hF, IW'(32'h100 + i));
            if (i < 4) ref_mem[a[i]] = d[i];
            n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, gnt_o); end
            if (i > 0) begin
                n_cmp++; if ({r_valid_o, r_id_o} !== {1'b1, IW'(32'h100 + i - 1)}) begin
                    n_err++; $display("FAIL b2b_resp[%0d]: got valid=%b id=%h expected 1 %h", i, r_valid_o, r_id_o, IW'(32'h100 + i - 1)); end
                n_cmp++; if (r_data_o !== ((i - 1 >= 4) ? d[(i - 1) % 4] : 32'h0)) begin
                    n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, r_data_o, ((i - 1 >= 4) ? d[(i - 1) % 4] : 32'h0)); end
            end
        end
        idle();
        n_cmp++; if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 20'h00107, d[3]}) begin
            n_err++; $display("FAIL b2b_last: got valid=%b id=%h data=%h expected 1 00107 %h", r_valid_o, r_id_o, r_data_o, d[3]); end
    endtask

    task automatic test_null_write();
        preload(14'h30, 32'h5555_5555);
        drive(1'b0, 1'b1, 1'b0, 14'h30, $urandom, 4'h0, 20'h00033);
        n_cmp++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL null_gnt: got %b expected 1", gnt_o); end
        n_cmp++; if (sram_req_o !== 1'b0) begin n_err++; $display("FAIL null_sram_req: got %b expected 0", sram_req_o); end
        drive(1'b0, 1'b1, 1'b1, 14'h30, 32'h0, 4'hF, 20'h00034);
        n_cmp++; if ({r_valid_o, r_id_o, r_data_o} !== {1'b1, 20'h00033, 32'h0}) begin
            n_err++; $display("FAIL null_resp: got valid=%b id=%h data=%h expected 1 00033 0", r_valid_o, r_id_o, r_data_o); end
        idle();
        n_cmp++; if (r_data_o !== 32'h5555_5555) begin n_err++; $display("FAIL null_mem: got %h expected 55555555", r_data_o); end
    endtask

    task automatic test_reset_mid_rmw();
        preload(14'h40, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 14'h40, 32'hCAFE_F00D, 4'b0011, 20'h00040);
        n_cmp++; if ({gnt_o, sram_req_o, sram_we_o} !== 3'b110) begin
            n_err++; $display("FAIL rmr_accept: got gnt=%b req=%b we=%b expected 1 1 0", gnt_o, sram_req_o, sram_we_o); end
        drive(1'b1, 1'b0, 1'b1, '0, '0, '0, '0);
        n_cmp++; if ({gnt_o, sram_req_o} !== 2'b00) begin
            n_err++; $display("FAIL rmr_abort: got gnt=%b sram_req=%b expected 0 0", gnt_o, sram_req_o); end
        idle();
        n_cmp++; if ({gnt_o, r_valid_o, r_id_o} !== {1'b1, 1'b0, 20'h0}) begin
            n_err++; $display("FAIL rmr_after: got gnt=%b valid=%b id=%h expected 1 0 00000", gnt_o, r_valid_o, r_id_o); end
        drive(1'b0, 1'b1, 1'b1, 14'h40, 32'h0, 4'hF, 20'h00041);
        idle();
        n_cmp++; if ({r_valid_o, r_data_o} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL rmr_mem: got valid=%b data=%h expected 1 00000000", r_valid_o, r_data_o); end
    endtask

    task automatic test_random();
        logic          r_req, r_wen, pend, acc, prev_acc, exp_gnt;
        logic [AW-1:0] r_add;
        logic [DW-1:0] r_dat, prev_rdata;
        logic [NB-1:0] r_be;
        logic [IW-1:0] r_id, prev_id;
        int            kind;
        for (int i = 0; i < 16; i++) preload(AW'(32'h300 + i), $urandom);
        idle();
        pend = 1'b0; prev_acc = 1'b0; exp_gnt = 1'b1;
        prev_rdata = '0; prev_id = '0;
        r_req = 1'b0; r_wen = 1'b1; r_add = '0; r_dat = '0; r_be = '0; r_id = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                r_req = ($urandom_range(0, 3) != 0);
                kind  = $urandom_range(0, 3);
                r_wen = (kind == 0);
                r_add = AW'(32'h300 + $urandom_range(0, 15));
                r_dat = $urandom;
                r_be  = (kind == 1) ? 4'hF : (kind == 3) ? 4'h0 : NB'($urandom_range(1, 14));
                r_id  = IW'($urandom);
            end
            drive(1'b0, r_req, r_wen, r_add, r_dat, r_be, r_id);
            n_cmp++; if (r_valid_o !== prev_acc) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", c, r_valid_o, prev_acc); end
            if (prev_acc) begin
                n_cmp++; if (r_id_o !== prev_id) begin n_err++; $display("FAIL rnd_rid[%0d]: got %h expected %h", c, r_id_o, prev_id); end
                n_cmp++; if (r_data_o !== prev_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, r_data_o, prev_rdata); end
            end
            n_cmp++; if (gnt_o !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt_o, exp_gnt); end
            acc      = r_req && exp_gnt;
            prev_acc = acc;
            if (acc) begin
                prev_id    = r_id;
                prev_rdata = r_wen ? ref_mem[r_add] : '0;
                if (!r_wen) ref_mem[r_add] = merge(ref_mem[r_add], r_dat, r_be);
            end
            exp_gnt = !(acc && !r_wen && r_be != 4'h0 && r_be != 4'hF);
            pend    = r_req && !acc;
        end
        idle();
        n_cmp++; if (r_valid_o !== prev_acc) begin n_err++; $display("FAIL rnd_tail_rvalid: got %b expected %b", r_valid_o, prev_acc); end
        if (prev_acc) begin
            n_cmp++; if ({r_id_o, r_data_o} !== {prev_id, prev_rdata}) begin
                n_err++; $display("FAIL rnd_tail_resp: got id=%h data=%h expected %h %h", r_id_o, r_data_o, prev_id, prev_rdata); end
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (sram_mem[AW'(32'h300 + i)] !== ref_mem[AW'(32'h300 + i)]) begin
                n_err++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, sram_mem[AW'(32'h300 + i)], ref_mem[AW'(32'h300 + i)]); end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_i = 1'b1; req_i = 1'b0; wen_i = 1'b1; add_i = '0;
        data_i = '0; be_i = '0; id_i = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_read();
        test_partial_write();
        test_back_to_back();
        test_null_write();
        test_reset_mid_rmw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
